// File: rtl/register_file_pkg.sv
// Shared widths and architectural register addresses for the register file.
package register_file_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 3;

    // Fixed architectural map; addresses 5..7 are general purpose.
    localparam int REG_A  = 0;
    localparam int REG_X  = 1;
    localparam int REG_Y  = 2;
    localparam int REG_Z  = 3;
    localparam int REG_SP = 4;

    function automatic int reg_count(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/register_file_reg_cell.sv
// One storage word: loads d on a rising clk when load is high, clears asynchronously.
module rf_reg_cell #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/register_file.sv
// Register file: one write port through a one-hot decoder, two independent
// combinational read ports with no write-to-read bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg_addr1,
    input  logic [ADDR_W-1:0] reg_addr2,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enable,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2
);

    localparam int NUM_REGS = reg_count(ADDR_W);

    logic [NUM_REGS-1:0] write_sel;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
            // The cell's own reset term blocks any load while rst is high.
            assign write_sel[gi] = write_enable && (write_addr == ADDR_W'(gi));

            rf_reg_cell #(
                .DATA_W (DATA_W)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .load (write_sel[gi]),
                .d    (write_data),
                .q    (reg_q[gi])
            );
        end
    endgenerate

    // Every address value selects a real cell, so the outputs are never X once reset.
    assign out_1 = reg_q[reg_addr1];
    assign out_2 = reg_q[reg_addr2];

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed checks of register_file against an array model.
`timescale 1ns/100ps
module tb_register_file;
    import register_file_pkg::*;

    localparam int DW = DEFAULT_DATA_W;
    localparam int AW = DEFAULT_ADDR_W;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] reg_addr1 = '0;
    logic [AW-1:0] reg_addr2 = '0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] out_1;
    logic [DW-1:0] out_2;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] ref_regs [N];

    register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_addr1    (reg_addr1),
        .reg_addr2    (reg_addr2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .out_1        (out_1),
        .out_2        (out_2)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check_eq({tag, "_out1"}, out_1, ref_regs[reg_addr1]);
        check_eq({tag, "_out2"}, out_2, ref_regs[reg_addr2]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) ref_regs[i] = '0;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        reg_addr1    = a1;
        reg_addr2    = a2;
        #1;
    endtask

    // Model update: a register takes the write data at the edge unless reset is high.
    task automatic do_edge();
        @(posedge clk);
        if (write_enable && !rst) ref_regs[write_addr] = write_data;
        #1;
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            reg_addr1 = AW'(i);
            reg_addr2 = AW'(N - 1 - i);
            #1;
            check_eq({tag, "_out1"}, out_1, 8'h00);
            check_eq({tag, "_out2"}, out_2, 8'h00);
        end
    endtask

    initial begin
        clear_model();
        #3;
        sweep_zero("reset_state");
        $display("txn reset: all addresses read zero");

        // Writes attempted while reset is held must be dropped.
        write_enable = 1'b1; write_addr = 3'd2; write_data = 8'h99;
        do_edge();
        reg_addr1 = 3'd2; reg_addr2 = 3'd2; #1;
        check_eq("rst_blocks_write", out_1, 8'h00);
        $display("txn write under reset: addr 2 reads 0x%02h", out_1);

        @(negedge clk);
        rst = 1'b0;
        write_enable = 1'b0;

        drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd3);
        check_eq("idle_y", out_1, 8'h00);
        check_eq("idle_z", out_2, 8'h00);
        $display("txn read Y/Z after reset: 0x%02h 0x%02h", out_1, out_2);

        drive(1'b1, REG_A, 8'hAA, 3'd0, 3'd1);
        do_edge();
        drive(1'b1, REG_X, 8'h55, 3'd0, 3'd1);
        do_edge();
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
        check_eq("wr_a", out_1, 8'hAA);
        check_eq("wr_x", out_2, 8'h55);
        $display("txn write A/X: 0x%02h 0x%02h", out_1, out_2);

        drive(1'b1, REG_SP, 8'h0F, 3'd4, 3'd0);
        do_edge();
        drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd0);
        check_eq("wr_sp", out_1, 8'h0F);
        check_eq("a_kept", out_2, 8'hAA);
        $display("txn write SP: 0x%02h A=0x%02h", out_1, out_2);

        drive(1'b0, REG_X, 8'hFF, 3'd1, 3'd1);
        repeat (3) do_edge();
        check_eq("we_low_hold1", out_1, 8'h55);
        check_eq("we_low_hold2", out_2, 8'h55);
        $display("txn hold with enable low: X=0x%02h", out_1);

        drive(1'b1, 3'd7, 8'h3C, 3'd7, 3'd7);
        check_eq("rdw_old1", out_1, 8'h00);
        check_eq("rdw_old2", out_2, 8'h00);
        do_edge();
        check_eq("rdw_new1", out_1, 8'h3C);
        check_eq("rdw_new2", out_2, 8'h3C);
        $display("txn read-during-write addr 7: 0x%02h", out_1);

        for (int t = 0; t < 120; t++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom));
            check_ports("rnd_pre");
            do_edge();
            check_ports("rnd_post");
            $display("txn rnd %0d: we=%0d wa=%0d wd=0x%02h a1=%0d a2=%0d -> 0x%02h 0x%02h",
                     t, write_enable, write_addr, write_data, reg_addr1, reg_addr2, out_1, out_2);
        end

        // Make sure storage is non-zero before checking the asynchronous clear.
        drive(1'b1, 3'd3, 8'hE7, 3'd3, 3'd3);
        do_edge();
        check_eq("pre_async", out_1, 8'hE7);
        write_enable = 1'b0;
        #1;
        rst = 1'b1;
        clear_model();
        sweep_zero("async_rst");
        $display("txn async reset mid-cycle: all zero before the edge");

        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3'd5, 8'h77, 3'd5, 3'd5);
        do_edge();
        check_eq("wr_gp5", out_1, 8'h77);
        #1;
        rst = 1'b1;
        clear_model();
        #1;
        check_eq("rst_wins", out_1, 8'h00);
        $display("txn reset after write to 5: reads 0x%02h", out_1);

        @(negedge clk);
        rst = 1'b0;
        write_enable = 1'b1; write_addr = 3'd6; write_data = 8'hC3;
        reg_addr1 = 3'd6; reg_addr2 = 3'd5;
        do_edge();
        check_eq("first_wr_after_rst", out_1, 8'hC3);
        check_eq("gp5_cleared", out_2, 8'h00);
        $display("txn first write after reset: 0x%02h", out_1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register and data width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; the register count SHALL be 2**ADDR_W (8 by default).
REQ-003 clk  input  1  SHALL be the single clock; all writes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 reg_addr1  input  ADDR_W  SHALL select the register driven on out_1.
REQ-006 reg_addr2  input  ADDR_W  SHALL select the register driven on out_2.
REQ-007 write_addr  input  ADDR_W  SHALL select the register to write.
REQ-008 write_data  input  DATA_W  SHALL carry the value to write.
REQ-009 write_enable  input  1  SHALL, when high, enable a write on the next rising clk edge.
REQ-010 out_1  output  DATA_W  SHALL carry the contents of register reg_addr1.
REQ-011 out_2  output  DATA_W  SHALL carry the contents of register reg_addr2.

Function
REQ-012 Register map SHALL be fixed: 0=A, 1=X, 2=Y, 3=Z, 4=SP; 5-7 SHALL be general-purpose and fully readable and writable.
REQ-013 On a rising clk with write_enable=1 and rst=0, register[write_addr] SHALL take write_data; all other registers SHALL hold their values.
REQ-014 With write_enable=0, no register SHALL change.
REQ-015 Both read ports SHALL be combinational (zero-cycle latency) and independent.
REQ-016 Both read ports SHALL be allowed to address the same register at once, and both SHALL return the same value.
REQ-017 Read-during-write: before the edge, a read of write_addr SHALL return the old value. From the edge onward it SHALL return the new value. There SHALL be no write-to-read bypass.
REQ-018 Write latency SHALL be one edge: data written at edge N SHALL be visible on the outputs immediately after edge N.
REQ-019 Addresses SHALL be full-range decoded; no address SHALL be invalid or ignored.
REQ-020 Outputs SHALL never be X after reset, whatever the address values.

Reset
REQ-021 Asserting rst SHALL clear all registers to 0 immediately, without waiting for a clock edge.
REQ-022 While rst is high, out_1 and out_2 SHALL read 0 and writes SHALL be blocked.
REQ-023 If rst asserts in the same cycle as a write, reset SHALL win and the register SHALL read 0.
REQ-024 After rst deasserts, the first rising edge with write_enable=1 SHALL perform a normal write.

Structure
REQ-025 A shared package SHALL hold DATA_W/ADDR_W defaults and the address constants REG_A=0, REG_X=1, REG_Y=2, REG_Z=3, REG_SP=4.
REQ-026 One sub-module, rf_reg_cell, SHALL be used: a DATA_W register with async reset and load enable, instantiated 2**ADDR_W times.
REQ-027 The top level SHALL contain a write-address decoder that drives the cell enables and two read multiplexers.

Verification
REQ-028 Write 0xAA to addr 0, then 0x55 to addr 1 on consecutive edges; set write_enable=0 and read addr 0/1 -> out_1=0xAA, out_2=0x55.
REQ-029 After reset, with no writes, read addr 2/3 -> out_1=0x00, out_2=0x00.
REQ-030 Write 0x0F to addr 4 (SP), then read addr 4/0 -> out_1=0x0F, out_2=0xAA (A unchanged).
REQ-031 Hold write_enable=0 with write_addr=1 and write_data=0xFF across 3 edges -> addr 1 still reads 0x55.
REQ-032 Assert rst mid-cycle after the writes above -> out_1/out_2 read 0x00 at once for every address, before any clock edge.
REQ-033 Set reg_addr1=reg_addr2=write_addr=7, write_enable=1, write_data=0x3C -> both outputs read the old value before the edge and 0x3C after it.
